// File: rtl/dbg_access_ctrl.sv
// Sequenced debug access engine: turns host commands into handshaked
// regfile / dmem / imem accesses, including register dumps and dmem bursts.
module dbg_access_ctrl #(
    parameter int unsigned REG_SIZE      = 32,
    parameter int unsigned REG_ADDR_SIZE = 5,
    parameter int unsigned REG_RD_LAT    = 0,
    parameter int unsigned MEM_RD_LAT    = 1,
    parameter int unsigned BURST_W       = 8,
    parameter int unsigned ADDR_STEP     = 1,
    parameter logic [1:0]  DMEM_WE_WORD  = 2'b11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [2:0]               cmd_op_i,
    input  logic [REG_SIZE-1:0]      cmd_addr_i,
    input  logic [REG_SIZE-1:0]      cmd_wdata_i,
    input  logic [BURST_W-1:0]       cmd_len_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [REG_SIZE-1:0]      rsp_data_o,
    output logic [REG_SIZE-1:0]      rsp_addr_o,
    output logic                     rsp_last_o,
    output logic                     rsp_err_o,
    output logic [REG_ADDR_SIZE-1:0] rs1_o,
    input  logic [REG_SIZE-1:0]      rv1_i,
    output logic [REG_ADDR_SIZE-1:0] rd_o,
    output logic                     reg_we_o,
    output logic [REG_SIZE-1:0]      reg_indata_o,
    output logic [REG_SIZE-1:0]      dmem_daddr_o,
    output logic [1:0]               dmem_we_o,
    output logic [REG_SIZE-1:0]      dmem_indata_o,
    input  logic [REG_SIZE-1:0]      dmem_outdata_i,
    output logic [REG_SIZE-1:0]      imem_iaddr_o,
    input  logic [REG_SIZE-1:0]      imem_idata_i
);

    localparam int unsigned DCNT_W = REG_ADDR_SIZE + 1;

    localparam logic [2:0] OP_REG_RD     = 3'd0;
    localparam logic [2:0] OP_REG_WR     = 3'd1;
    localparam logic [2:0] OP_DMEM_RD    = 3'd2;
    localparam logic [2:0] OP_DMEM_WR    = 3'd3;
    localparam logic [2:0] OP_IMEM_RD    = 3'd4;
    localparam logic [2:0] OP_REG_DUMP   = 3'd5;
    localparam logic [2:0] OP_DMEM_BURST = 3'd6;
    localparam logic [2:0] OP_ILLEGAL    = 3'd7;

    localparam logic [1:0]        REG_LAT   = 2'(REG_RD_LAT);
    localparam logic [1:0]        MEM_LAT   = 2'(MEM_RD_LAT);
    localparam logic [DCNT_W-1:0] DUMP_LAST = {1'b0, {REG_ADDR_SIZE{1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [REG_SIZE-1:0]     addr_q, addr_d;
    logic [REG_SIZE-1:0]     wdata_q, wdata_d;
    logic [BURST_W-1:0]      beats_q, beats_d;
    logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
    logic [1:0]              lat_q, lat_d;

    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [REG_SIZE-1:0]      rsp_data_q, rsp_data_d;
    logic [REG_SIZE-1:0]      rsp_addr_q, rsp_addr_d;
    logic                     rsp_last_q, rsp_last_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [REG_ADDR_SIZE-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_SIZE-1:0] rd_q, rd_d;
    logic                     reg_we_q, reg_we_d;
    logic [REG_SIZE-1:0]      reg_indata_q, reg_indata_d;
    logic [REG_SIZE-1:0]      dmem_daddr_q, dmem_daddr_d;
    logic [1:0]               dmem_we_q, dmem_we_d;
    logic [REG_SIZE-1:0]      dmem_indata_q, dmem_indata_d;
    logic [REG_SIZE-1:0]      imem_iaddr_q, imem_iaddr_d;

    logic                    cmd_bad;
    logic                    is_write;
    logic [1:0]              lat_sel;
    logic [REG_SIZE-1:0]     rd_mux;
    logic [REG_SIZE-1:0]     beat_addr;
    logic                    beat_last;
    logic [REG_SIZE-1:0]     addr_inc;
    logic [DCNT_W-1:0]       dcnt_inc;
    logic                    capture;

    // Command legality, evaluated on the live command inputs in IDLE
    always_comb begin
        cmd_bad = 1'b0;
        if (cmd_op_i == OP_ILLEGAL) begin
            cmd_bad = 1'b1;
        end else if (cmd_op_i == OP_DMEM_BURST && cmd_len_i == '0) begin
            cmd_bad = 1'b1;
        end else if ((cmd_op_i == OP_REG_RD || cmd_op_i == OP_REG_WR) &&
                     cmd_addr_i[REG_SIZE-1:REG_ADDR_SIZE] != '0) begin
            cmd_bad = 1'b1;
        end
    end

    // Per-op helpers for the latched command: latency, read source, beat info
    always_comb begin
        is_write  = (op_q == OP_REG_WR) || (op_q == OP_DMEM_WR);
        lat_sel   = (op_q == OP_REG_RD || op_q == OP_REG_DUMP) ? REG_LAT : MEM_LAT;
        addr_inc  = addr_q + REG_SIZE'(ADDR_STEP);
        dcnt_inc  = dcnt_q + DCNT_W'(1);
        beat_addr = (op_q == OP_REG_DUMP) ? REG_SIZE'(dcnt_q) : addr_q;
        case (op_q)
            OP_REG_RD, OP_REG_DUMP:    rd_mux = rv1_i;
            OP_DMEM_RD, OP_DMEM_BURST: rd_mux = dmem_outdata_i;
            OP_IMEM_RD:                rd_mux = imem_idata_i;
            default:                   rd_mux = '0;
        endcase
        case (op_q)
            OP_REG_DUMP:   beat_last = (dcnt_q == DUMP_LAST);
            OP_DMEM_BURST: beat_last = (beats_q == BURST_W'(1));
            default:       beat_last = 1'b1;
        endcase
    end

    // Next-state and next-output logic; strobes default low every cycle
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        beats_d       = beats_q;
        dcnt_d        = dcnt_q;
        lat_d         = lat_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_last_d    = rsp_last_q;
        rsp_err_d     = rsp_err_q;
        rs1_d         = rs1_q;
        rd_d          = rd_q;
        reg_we_d      = 1'b0;
        reg_indata_d  = reg_indata_q;
        dmem_daddr_d  = dmem_daddr_q;
        dmem_we_d     = 2'b00;
        dmem_indata_d = dmem_indata_q;
        imem_iaddr_d  = imem_iaddr_q;
        capture       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d        = cmd_op_i;
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    beats_d     = cmd_len_i;
                    dcnt_d      = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_bad) begin
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_addr_d  = cmd_addr_i;
                        rsp_last_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        case (cmd_op_i)
                            OP_REG_RD: rs1_d = cmd_addr_i[REG_ADDR_SIZE-1:0];
                            OP_REG_WR: begin
                                rd_d         = cmd_addr_i[REG_ADDR_SIZE-1:0];
                                reg_we_d     = 1'b1;
                                reg_indata_d = cmd_wdata_i;
                            end
                            OP_DMEM_RD, OP_DMEM_BURST: dmem_daddr_d = cmd_addr_i;
                            OP_DMEM_WR: begin
                                dmem_daddr_d  = cmd_addr_i;
                                dmem_we_d     = DMEM_WE_WORD;
                                dmem_indata_d = cmd_wdata_i;
                            end
                            OP_IMEM_RD:  imem_iaddr_d = cmd_addr_i;
                            OP_REG_DUMP: rs1_d = '0;
                            default: ;
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                if (is_write) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wdata_q;
                    rsp_addr_d  = addr_q;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b0;
                end else if (lat_sel == 2'd0) begin
                    capture = 1'b1;
                end else begin
                    lat_d   = lat_sel - 2'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == 2'd0) begin
                    capture = 1'b1;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d     = ST_IDLE;
                        cmd_ready_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        if (op_q == OP_REG_DUMP) begin
                            dcnt_d = dcnt_inc;
                            rs1_d  = dcnt_inc[REG_ADDR_SIZE-1:0];
                        end else begin
                            addr_d       = addr_inc;
                            beats_d      = beats_q - BURST_W'(1);
                            dmem_daddr_d = addr_inc;
                        end
                    end
                end
            end
            ST_ERR: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_mux;
            rsp_addr_d  = beat_addr;
            rsp_last_d  = beat_last;
            rsp_err_d   = 1'b0;
        end
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            beats_q       <= '0;
            dcnt_q        <= '0;
            lat_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            rsp_last_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            rs1_q         <= '0;
            rd_q          <= '0;
            reg_we_q      <= 1'b0;
            reg_indata_q  <= '0;
            dmem_daddr_q  <= '0;
            dmem_we_q     <= 2'b00;
            dmem_indata_q <= '0;
            imem_iaddr_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            beats_q       <= beats_d;
            dcnt_q        <= dcnt_d;
            lat_q         <= lat_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_last_q    <= rsp_last_d;
            rsp_err_q     <= rsp_err_d;
            rs1_q         <= rs1_d;
            rd_q          <= rd_d;
            reg_we_q      <= reg_we_d;
            reg_indata_q  <= reg_indata_d;
            dmem_daddr_q  <= dmem_daddr_d;
            dmem_we_q     <= dmem_we_d;
            dmem_indata_q <= dmem_indata_d;
            imem_iaddr_q  <= imem_iaddr_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_addr_o    = rsp_addr_q;
    assign rsp_last_o    = rsp_last_q;
    assign rsp_err_o     = rsp_err_q;
    assign rs1_o         = rs1_q;
    assign rd_o          = rd_q;
    assign reg_we_o      = reg_we_q;
    assign reg_indata_o  = reg_indata_q;
    assign dmem_daddr_o  = dmem_daddr_q;
    assign dmem_we_o     = dmem_we_q;
    assign dmem_indata_o = dmem_indata_q;
    assign imem_iaddr_o  = imem_iaddr_q;

endmodule
